// File: rtl/enc_sched_pkg.sv
// enc_sched_pkg: shared defaults and FSM state type for the encoder sample scheduler
package enc_sched_pkg;
  localparam int DEF_NUM_ENC = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_PERIOD_CYCLES = 50000;
  typedef enum logic [1:0] {PRIME, IDLE, SEND} state_t;
endpackage

// File: rtl/enc_tick_gen.sv
// enc_tick_gen: sample-period counter producing a one-cycle tick at the end of each period
module enc_tick_gen import enc_sched_pkg::*; #(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(PERIOD_CYCLES);
  localparam logic [W-1:0] LAST = W'(PERIOD_CYCLES - 1);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == LAST;
  // count while enabled, wrap on the tick, park at zero when disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!enable || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/enc_sample_sched.sv
// enc_sample_sched: snapshots encoder counts each period and streams per-encoder deltas;
// define ENC_SCHED_OVERRUN_CNT_EN to add the saturating overrun_cnt output
module enc_sample_sched import enc_sched_pkg::*; #(
  parameter int NUM_ENC = DEF_NUM_ENC,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  localparam int IW = NUM_ENC > 1 ? $clog2(NUM_ENC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_ENC*CNT_W-1:0] enc_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_data,
  output logic [IW-1:0]            out_id,
  output logic                     out_last,
  output logic                     overrun,
  input  logic                     clr_overrun
`ifdef ENC_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]               overrun_cnt
`endif
);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_ENC - 1);
  state_t state;
  logic tick, primed, fire, last_fire, snap, drop;
  logic [IW-1:0] nxt_id;
  logic [CNT_W-1:0] prev [NUM_ENC];
  logic [CNT_W-1:0] delta [NUM_ENC];
  logic [CNT_W-1:0] d_new [NUM_ENC];

  enc_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick)
  );

  assign fire = out_valid && out_ready;
  assign last_fire = fire && out_last;
  assign snap = tick && primed && (state == IDLE || (state == SEND && last_fire));
  assign drop = tick && state == SEND && !last_fire;
  assign nxt_id = out_id + 1'b1;

  // deltas the next snapshot would capture, modulo 2^CNT_W
  always_comb
    for (int i = 0; i < NUM_ENC; i++) d_new[i] = enc_count[i*CNT_W +: CNT_W] - prev[i];

  // PRIME/IDLE/SEND sequencer; primed drops with enable so a stale prev is never differenced
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PRIME;
      primed <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_id <= '0;
      out_data <= '0;
      for (int i = 0; i < NUM_ENC; i++) begin
        prev[i] <= '0;
        delta[i] <= '0;
      end
    end else begin
      primed <= enable && (primed || (state == PRIME && tick));
      if (snap) begin
        for (int i = 0; i < NUM_ENC; i++) begin
          prev[i] <= enc_count[i*CNT_W +: CNT_W];
          delta[i] <= d_new[i];
        end
        state <= SEND;
        out_valid <= 1'b1;
        out_id <= '0;
        out_data <= d_new[0];
        out_last <= NUM_ENC == 1;
      end else if (state == PRIME) begin
        if (tick) begin
          for (int i = 0; i < NUM_ENC; i++) prev[i] <= enc_count[i*CNT_W +: CNT_W];
          state <= IDLE;
        end
      end else if (state == IDLE) begin
        if (!primed) state <= PRIME;
      end else if (fire) begin
        if (out_last) begin
          state <= primed ? IDLE : PRIME;
          out_valid <= 1'b0;
          out_last <= 1'b0;
        end else begin
          out_id <= nxt_id;
          out_data <= delta[nxt_id];
          out_last <= nxt_id == LAST_ID;
        end
      end
    end

  // sticky drop flag; a new drop beats a coincident clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overrun <= 1'b0;
    else overrun <= drop || (overrun && !clr_overrun);

`ifdef ENC_SCHED_OVERRUN_CNT_EN
  // saturating count of dropped ticks; increment beats a coincident clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overrun_cnt <= '0;
    else if (drop) overrun_cnt <= overrun_cnt + {7'd0, overrun_cnt != 8'hFF};
    else if (clr_overrun) overrun_cnt <= '0;
`endif
endmodule

// File: tb/tb_enc_sample_sched.sv
// tb_enc_sample_sched: randomized and directed checks of enc_sample_sched against a queue-based model
module tb_enc_sample_sched;
  localparam int N = 4, W = 8, P = 10;
  logic clk = 0, rst_n = 0, enable = 0, out_ready = 0, clr_overrun = 0;
  logic [N*W-1:0] enc_count = '0;
  logic out_valid, out_last, overrun;
  logic [W-1:0] out_data;
  logic [1:0] out_id;
`ifdef ENC_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif
  typedef struct packed {logic [7:0] d; logic [1:0] id; logic last;} beat_t;
  beat_t exp_q[$], obs[$];
  logic [7:0] cnt [N], prev_m [N];
  logic primed_m, ovr_m;
  int pc_m, ocnt_m;
  int n_chk = 0, n_fail = 0;

  enc_sample_sched #(.NUM_ENC(N), .CNT_W(W), .PERIOD_CYCLES(P)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .enc_count(enc_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .overrun(overrun), .clr_overrun(clr_overrun)
`ifdef ENC_SCHED_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    primed_m = 0;
    ovr_m = 0;
    pc_m = 0;
    ocnt_m = 0;
    for (int i = 0; i < N; i++) prev_m[i] = '0;
  endtask

  task automatic setc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
  endtask

  // one clock: drive at negedge, check outputs against the model, advance the model over the posedge
  task automatic cyc(input logic rdy, input logic clr);
    logic tick, set;
    logic [7:0] dv;
    out_ready = rdy;
    clr_overrun = clr;
    for (int i = 0; i < N; i++) enc_count[i*W +: W] = cnt[i];
    #1;
    chk("valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("data", out_data, exp_q[0].d);
      chk("id", out_id, exp_q[0].id);
      chk("last", out_last, exp_q[0].last);
    end
    chk("overrun", overrun, ovr_m);
`ifdef ENC_SCHED_OVERRUN_CNT_EN
    chk("overrun_cnt", overrun_cnt, ocnt_m);
`endif
    if (exp_q.size() != 0 && rdy) begin
      obs.push_back('{d: out_data, id: out_id, last: out_last});
      void'(exp_q.pop_front());
    end
    tick = enable && pc_m == P - 1;
    set = tick && exp_q.size() != 0;
    if (tick && !set) begin
      if (!primed_m) primed_m = 1;
      else
        for (int i = 0; i < N; i++) begin
          dv = cnt[i] - prev_m[i];
          exp_q.push_back('{d: dv, id: 2'(i), last: i == N - 1});
        end
      for (int i = 0; i < N; i++) prev_m[i] = cnt[i];
    end
    ovr_m = set ? 1'b1 : clr ? 1'b0 : ovr_m;
    ocnt_m = set ? (ocnt_m == 255 ? 255 : ocnt_m + 1) : clr ? 0 : ocnt_m;
    if (!enable) primed_m = 0;
    pc_m = enable ? (pc_m == P - 1 ? 0 : pc_m + 1) : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sync();
    int k = 0;
    do begin
      cyc(1, 0);
      k++;
    end while (pc_m != 0 && k < 40);
    if (pc_m != 0) begin
      n_fail++;
      $display("FAIL sync: no tick within %0d cycles", k);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1, 0);
  endtask

  initial begin
    logic [7:0] e036 [N];
    logic [7:0] c1 [N];
    e036 = '{8'h05, 8'hFE, 8'h00, 8'h02};
    model_reset();
    setc(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    chk("rst_last", out_last, 0);
    chk("rst_overrun", overrun, 0);
`ifdef ENC_SCHED_OVERRUN_CNT_EN
    chk("rst_overrun_cnt", overrun_cnt, 0);
`endif
    rst_n = 1;
    enable = 1;
    setc(10, 20, 30, 40);
    repeat (P) cyc(1, 0);
    chk("prime_no_frame", out_valid, 0);
    setc(15, 18, 30, 8'h2A);
    obs.delete();
    sync();
    drain(4);
    chk("frame_beats", obs.size(), 4);
    for (int i = 0; i < N; i++) begin
      chk("frame_data", obs[i].d, e036[i]);
      chk("frame_id", obs[i].id, i);
      chk("frame_last", obs[i].last, i == N - 1);
    end
    setc(20, 25, 31, 50);
    obs.delete();
    sync();
    cyc(1, 0);
    repeat (5) cyc(0, 0);
    drain(3);
    chk("bp_beats", obs.size(), 4);
    chk("bp_beat1_id", obs[1].id, 1);
    chk("bp_beat1_data", obs[1].d, 8'd7);
    setc(50, 60, 70, 80);
    c1 = cnt;
    sync();
    repeat (5) cyc(0, 0);
    setc(70, 90, 75, 100);
    repeat (10) cyc(0, 0);
    chk("overrun_set", overrun, 1);
    drain(4);
    obs.delete();
    sync();
    drain(4);
    for (int i = 0; i < N; i++) chk("span_delta", obs[i].d, 8'(cnt[i] - c1[i]));
    cyc(1, 1);
    chk("overrun_clr", overrun, 0);
    setc(1, 2, 3, 4);
    sync();
    setc(9, 9, 9, 9);
    repeat (P) cyc(pc_m >= 6, 0);
    chk("coin_overrun", overrun, 0);
    chk("coin_valid", out_valid, 1);
    chk("coin_id", out_id, 0);
    drain(4);
    setc(8'hFE, 0, 0, 0);
    sync();
    drain(4);
    setc(8'h03, 0, 0, 0);
    obs.delete();
    sync();
    drain(4);
    chk("wrap_pos", obs[0].d, 8'h05);
    setc(8'hFE, 0, 0, 0);
    obs.delete();
    sync();
    drain(4);
    chk("wrap_neg", obs[0].d, 8'hFB);
    repeat (400) begin
      for (int i = 0; i < N; i++) cnt[i] = cnt[i] + 8'($urandom_range(0, 40));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    sync();
    drain(4);
    setc(30, 31, 32, 33);
    sync();
    enable = 0;
    drain(4);
    repeat (3) cyc(1, 0);
    enable = 1;
    setc(40, 41, 42, 43);
    sync();
    chk("reprime_no_frame", out_valid, 0);
    setc(45, 40, 52, 43);
    obs.delete();
    sync();
    drain(4);
    chk("reprime_delta", obs[0].d, 8'd5);
    chk("reprime_delta1", obs[1].d, 8'hFF);
`ifdef ENC_SCHED_OVERRUN_CNT_EN
    setc(1, 1, 1, 1);
    sync();
    repeat (301 * P) cyc(0, 0);
    chk("ocnt_sat", overrun_cnt, 8'hFF);
    drain(4);
    cyc(1, 1);
`endif
    setc(60, 61, 62, 63);
    sync();
    drain(2);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_id", out_id, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    setc(70, 71, 72, 73);
    sync();
    chk("post_rst_prime", out_valid, 0);
    setc(72, 71, 72, 80);
    obs.delete();
    sync();
    drain(4);
    chk("post_rst_delta", obs[3].d, 8'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
